pad_block_sequencer: RTL
========================

// Module: pad_block_sequencer
// PURPOSE
//   Byte-stream front end for the cipher datapath. Accepts plaintext one byte at a time and
//   packs it into 256-bit padded blocks: payload in [247:0], payload bit-length in [255:248].
//   A full block carries length 8'd248. Hands each block to the cipher core over valid/ready.
//   Tags the final block of each message and numbers blocks within a message.
// PARAMETERS
//   PAY_BYTES  31   payload bytes per block; block width = 8*(PAY_BYTES+1); legal range 1..31
//   IDX_W      8    width of the per-message block index
// PORTS
//   clk        in   1          rising-edge clock
//   reset      in   1          asynchronous, active-high; clears all state
//   in_valid   in   1          in_data is valid this cycle
//   in_ready   out  1          sequencer accepts a byte this cycle
//   in_data    in   8          plaintext byte
//   in_last    in   1          this byte ends the message (qualified by in_valid)
//   blk_valid  out  1          padded block available on blk_data
//   blk_ready  in   1          cipher core takes the block this cycle
//   blk_data   out  8*(PAY_BYTES+1)  padded block
//   blk_last   out  1          blk_data is the final block of its message
//   blk_idx    out  IDX_W      index of blk_data within its message; first block = 0
// BEHAVIOUR
//   Reset: state FILL; byte count 0; buffer 0; blk_valid 0; blk_last 0; blk_idx 0; in_ready 1.
//   Transfers: a byte moves when in_valid && in_ready; a block moves when blk_valid && blk_ready.
//   FSM states: FILL and EMIT.
//   FILL:
//     - in_ready = 1; blk_valid = 0.
//     - Accepted byte k (0-based in the block) is written to buffer bits [8k+7:8k]; count increments.
//     - Go to EMIT when the accepted byte is the last one (count reaches PAY_BYTES) or carries in_last.
//     - On that transition:
//         length byte [top 8 bits] <= 8*(bytes in block)
//         blk_last <= in_last of the accepted byte
//   EMIT:
//     - in_ready = 0; blk_valid = 1.
//     - blk_data, blk_last and blk_idx stay stable until the block transfers.
//     - On the block transfer:
//         buffer <= 0; count <= 0; state <= FILL
//         blk_idx <= 0 if blk_last, else blk_idx+1 (wraps mod 2^IDX_W)
//   Latency: the byte that completes a block is accepted in cycle t; blk_valid is 1 from t+1.
//     Back-to-back throughput: PAY_BYTES+1 cycles per block with blk_ready held high.
//   Unused payload bytes of a short final block read as 0.
//   in_last on byte PAY_BYTES-1: a single full block with length 248 and blk_last=1; no extra block.
//   in_valid is ignored in EMIT: no byte is lost and no byte is written.
//   blk_ready with blk_valid=0 has no effect.
//   blk_valid never drops without a transfer.
//   Reset asserted mid-block or mid-EMIT:
//     - discards the partial block immediately
//     - blk_valid falls asynchronously
//     - the next message restarts at blk_idx 0
//   All outputs are registered or derived from the state register only; no combinational in->out path.
// TESTING
//   1. One message of bytes 0x01..0x1F, in_last on 0x1F, blk_ready=1
//      -> one block: [247:0]=bytes with 0x01 in [7:0]; [255:248]=248; blk_last=1; blk_idx=0.
//   2. One message of 3 bytes AA,BB,CC with in_last
//      -> blk_data[23:0]=CCBBAA; [247:24]=0; [255:248]=24; blk_last=1.
//   3. 40-byte message
//      -> block idx0: len 248, last=0; then block idx1: len 72, last=1; blk_idx back to 0 afterwards.
//   4. blk_ready low for 10 cycles during EMIT with in_valid held
//      -> blk_data stable; in_ready=0; no byte consumed; the next block starts with the held byte.
//   5. Assert reset after 5 bytes, then send 2-byte message
//      -> only the 2-byte block appears, len 16, idx 0.
//   6. 300 consecutive 1-byte messages with blk_ready=1
//      -> every block has idx 0 and len 8; each block completes in 2 cycles.

Source files
------------

// File: rtl/pad_block_sequencer.sv
// Purpose: packs a plaintext byte stream into padded blocks {length byte, payload} for the cipher core.
// Latency: the block is presented the cycle after its closing byte is accepted; PAY_BYTES+1 cycles per full block.
// Backpressure: in_ready is low while a block waits in EMIT; the block and its tags hold until blk_ready takes it.
module pad_block_sequencer #(
    parameter int PAY_BYTES = 31,
    parameter int IDX_W     = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [7:0]                   in_data,
    input  logic                         in_last,
    output logic                         blk_valid,
    input  logic                         blk_ready,
    output logic [8*(PAY_BYTES+1)-1:0]   blk_data,
    output logic                         blk_last,
    output logic [IDX_W-1:0]             blk_idx
);

    localparam int PAY_W = 8 * PAY_BYTES;
    localparam int CNT_W = $clog2(PAY_BYTES + 1);

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    // Length byte sits on top of the payload so the block leaves as one packed word.
    typedef struct packed {
        logic [7:0]       len;
        logic [PAY_W-1:0] pay;
    } blk_t;

    logic [0:0]       state;
    blk_t             blk;
    logic [CNT_W-1:0] count;
    logic             take_byte;
    logic             take_blk;
    logic             close_blk;
    logic [7:0]       bytes_in_blk;

    // Handshakes depend on the state register only, so there is no input-to-output path.
    assign in_ready  = (state == FILL);
    assign blk_valid = (state == EMIT);
    assign blk_data  = blk;

    assign take_byte    = in_valid && in_ready;
    assign take_blk     = blk_valid && blk_ready;
    assign bytes_in_blk = 8'(count) + 8'd1;

    // A block closes on the byte that fills the last payload slot or on a message end.
    assign close_blk = take_byte && (in_last || (count == CNT_W'(PAY_BYTES - 1)));

    // Fill the buffer byte by byte, then hold the finished block until the core takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FILL;
            blk      <= '0;
            count    <= '0;
            blk_last <= 1'b0;
            blk_idx  <= '0;
        end else if (state == FILL) begin
            if (take_byte) begin
                for (int k = 0; k < PAY_BYTES; k++) begin
                    if (count == CNT_W'(k)) begin
                        blk.pay[8*k +: 8] <= in_data;
                    end
                end
                count <= count + CNT_W'(1);
                if (close_blk) begin
                    // Length is in bits: eight per byte actually carried in this block.
                    blk.len  <= 8'(bytes_in_blk << 3);
                    blk_last <= in_last;
                    state    <= EMIT;
                end
            end
        end else begin
            if (take_blk) begin
                // Clearing the buffer keeps unused bytes of a later short block at zero.
                blk     <= '0;
                count   <= '0;
                state   <= FILL;
                blk_idx <= blk_last ? '0 : blk_idx + IDX_W'(1);
            end
        end
    end

endmodule
